// File: rtl/pattern_det_pkg.sv
// Shared types and default widths for the configurable serial pattern detector.
// Build option: PATDET_TIMEOUT_EN adds an idle-cycle timeout to the controller.
package pattern_det_pkg;

  localparam int DEF_PAT_W       = 8;
  localparam int DEF_LEN_W       = $clog2(DEF_PAT_W + 1);
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_TIMEOUT_CYC = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pattern_det_ctrl_matcher.sv
// History shift register, fill counter and length-masked compare; hit is combinational
// and reflects the bit being shifted in this cycle.
module pattern_matcher #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic             inp,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic             hit
);

  logic [PAT_W-1:0] history;
  logic [PAT_W-1:0] history_next;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_next;
  logic [PAT_W-1:0] mask;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    history_next = {history[PAT_W-2:0], inp};
    fill_next    = (fill == LEN_W'(PAT_W)) ? fill : fill + 1'b1;
    mask         = '0;
    for (int i = 0; i < PAT_W; i++) mask[i] = (i < int'(len));
    hit = shift && (fill_next >= len) && (((history_next ^ pattern) & mask) == '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      history <= '0;
      fill    <= '0;
    end else if (shift) begin
      history <= history_next;
      // Non-overlap mode only needs fill cleared: stale history bits can no longer satisfy fill >= len.
      fill    <= (hit && !overlap) ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/pattern_det_ctrl.sv
// Configurable serial pattern-detection controller: config handshake, IDLE/RUN/DONE FSM,
// match counting and limit. Build option: PATDET_TIMEOUT_EN enables the idle-cycle timeout.
module pattern_det_ctrl
  import pattern_det_pkg::*;
#(
  parameter int PAT_W       = DEF_PAT_W,
  parameter int LEN_W       = $clog2(PAT_W + 1),
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_limit,
  output logic             cfg_err,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             inp,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  state_t           state, state_next;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             overlap_q;
  logic [CNT_W-1:0] limit_q;
  logic             cfg_loaded;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_inc;
  logic             match_q;
  logic             err_q;

  logic cfg_accept, len_ok, run_start, shift, hit, limit_hit, tmo_expire;

  assign cfg_ready  = (state != RUN);
  assign cfg_accept = cfg_valid && cfg_ready;
  assign len_ok     = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
  // A same-cycle config offer takes precedence over start.
  assign run_start  = start && !cfg_accept &&
                      (((state == IDLE) && cfg_loaded) || (state == DONE));
  assign shift      = (state == RUN) && in_valid && !abort;
  assign count_inc  = (count_q == '1) ? count_q : count_q + 1'b1;
  assign limit_hit  = hit && (limit_q != '0) && (count_inc == limit_q);

  pattern_matcher #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_matcher (
    .clk     (clk),
    .rst     (rst),
    .clear   (run_start),
    .shift   (shift),
    .inp     (inp),
    .pattern (pat_q),
    .len     (len_q),
    .overlap (overlap_q),
    .hit     (hit)
  );

`ifdef PATDET_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_q;

  // A hit restarts the idle window instead of expiring it.
  assign tmo_expire = shift ? (!hit && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)))
                            : ((state == RUN) && !abort && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)));

  always_ff @(posedge clk) begin
    if (rst || run_start) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else if (state == RUN) begin
      tmo_cnt <= hit ? '0 : tmo_cnt + 1'b1;
      if (tmo_expire) tmo_q <= 1'b1;
    end
  end

  assign timeout = tmo_q && (state == DONE);
`else
  assign tmo_expire = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (run_start) state_next = RUN;
      RUN: begin
        if (abort)                        state_next = IDLE;
        else if (limit_hit || tmo_expire) state_next = DONE;
      end
      DONE: begin
        if (cfg_accept && len_ok) state_next = IDLE;
        else if (run_start)       state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pat_q      <= '0;
      len_q      <= '0;
      overlap_q  <= 1'b0;
      limit_q    <= '0;
      cfg_loaded <= 1'b0;
      count_q    <= '0;
      match_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state   <= state_next;
      match_q <= hit;
      err_q   <= cfg_accept && !len_ok;
      if (cfg_accept && len_ok) begin
        pat_q      <= cfg_pattern;
        len_q      <= cfg_len;
        overlap_q  <= cfg_overlap;
        limit_q    <= cfg_limit;
        cfg_loaded <= 1'b1;
      end
      if (run_start)  count_q <= '0;
      else if (hit)   count_q <= count_inc;
    end
  end

  assign cfg_err     = err_q;
  assign match       = match_q;
  assign match_count = count_q;
  assign busy        = (state == RUN);
  assign done        = (state == DONE);

endmodule
